// File: rtl/led_blink_code_sched.sv
// Status-LED blink-code scheduler: a round-robin arbiter picks one requester at
// a time, then a tick-paced FSM plays its code as ON/OFF pulses followed by an
// LED-off gap before the next code may start.
module led_blink_code_sched #(
  parameter  int TICK_DIV       = 6_750_000,
  parameter  int N_REQ          = 4,
  parameter  int CODE_W         = 4,
  parameter  int GAP_UNITS      = 4,
  parameter  int LED_ACTIVE_LOW = 1,
  localparam int IDW            = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*CODE_W-1:0] req_code,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    busy,
  output logic [IDW-1:0]          grant_id,
  output logic                    done,
  output logic                    led_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = (GAP_UNITS > 1) ? $clog2(GAP_UNITS) : 1;
  localparam logic OFF_LVL = (LED_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     presc_q;
  logic              tick;
  logic [CODE_W-1:0] rem_q, rem_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              lit_q, lit_d;
  logic              done_q, done_d;
  logic [IDW-1:0]    ptr_q, grant_q;
  logic [IDW-1:0]    win_id;
  logic              found;
  logic              accept;
  logic [CODE_W-1:0] code_sel;

  assign tick = (presc_q == PW'(TICK_DIV - 1));

  // Round-robin search: start just after the last grant, wrap, first valid wins.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    win_id = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        win_id = IDW'(idx);
      end
    end
  end

  assign accept    = (state_q == IDLE) && found;
  assign req_ready = accept ? (N_REQ'(1) << win_id) : '0;
  assign code_sel  = req_code[win_id*CODE_W +: CODE_W];

  // Time-unit prescaler; realigned on accept so the first ON unit is full length.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       presc_q <= '0;
    else if (accept) presc_q <= '0;
    else if (tick)   presc_q <= '0;
    else             presc_q <= presc_q + PW'(1);
  end

  // Arbiter pointer and reported grant; pointer resets so index 0 is first.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q   <= IDW'(N_REQ - 1);
      grant_q <= '0;
    end else if (accept) begin
      ptr_q   <= win_id;
      grant_q <= win_id;
    end
  end

  // FSM state and playback registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      rem_q   <= '0;
      gap_q   <= '0;
      lit_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      lit_q   <= lit_d;
      done_q  <= done_d;
    end
  end

  // Next-state: pulses count down rem in ON only, so a max code cannot wrap.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    lit_d   = lit_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        if (code_sel != '0) begin
          state_d = ON;
          rem_d   = code_sel;
          lit_d   = 1'b1;
        end else begin
          done_d  = 1'b1;
        end
      end
      ON: if (tick) begin
        rem_d   = rem_q - CODE_W'(1);
        state_d = OFF;
        lit_d   = 1'b0;
      end
      OFF: if (tick) begin
        if (rem_q == '0) begin
          state_d = GAP;
          gap_d   = '0;
        end else begin
          state_d = ON;
          lit_d   = 1'b1;
        end
      end
      GAP: if (tick) begin
        if (gap_q == GW'(GAP_UNITS - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          gap_d   = gap_q + GW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        lit_d   = 1'b0;
      end
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign grant_id = grant_q;
  assign done     = done_q;
  assign led_o    = lit_q ^ OFF_LVL;

endmodule

// File: tb/tb_led_blink_code_sched.sv
// Directed bench for led_blink_code_sched with a short time unit.
module tb_led_blink_code_sched;
  localparam int TD = 4, NR = 4, CW = 4, GU = 2;

  logic             clk, rstn;
  logic [NR-1:0]    req_valid;
  logic [NR*CW-1:0] req_code;
  logic [NR-1:0]    req_ready;
  logic             busy, done, led_o;
  logic [1:0]       grant_id;

  int n_chk = 0, n_err = 0;

  led_blink_code_sched #(.TICK_DIV(TD), .N_REQ(NR), .CODE_W(CW),
                         .GAP_UNITS(GU), .LED_ACTIVE_LOW(1)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_code(req_code),
    .req_ready(req_ready), .busy(busy), .grant_id(grant_id), .done(done),
    .led_o(led_o));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int id, input int code);
    req_valid[id] = 1'b1;
    req_code[id*CW +: CW] = CW'(code);
  endtask

  // Entered at the negedge of the expected accept cycle; returns at the negedge of
  // the done cycle, where a pending request may be accepted back-to-back.
  task automatic play(input int id, input int code);
    int L, bad, pulses;
    logic exp_led, prev_lit;
    #1;
    chk("req_ready_onehot", 32'(req_ready), 32'(1) << id);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    L = (code == 0) ? 1 : (2*code + GU)*TD + 1;
    bad = 0; pulses = 0; prev_lit = 1'b0;
    for (int c = 1; c <= L; c++) begin
      @(negedge clk);
      if (c == 1) chk("grant_id", 32'(grant_id), 32'(id));
      exp_led = (c <= 2*code*TD && ((c-1)/TD) % 2 == 0) ? 1'b0 : 1'b1;
      if (led_o !== exp_led) bad++;
      if (busy !== (c < L)) bad++;
      if (c < L && (done !== 1'b0 || req_ready !== '0)) bad++;
      if (!led_o && !prev_lit) pulses++;
      prev_lit = !led_o;
    end
    chk("done_at_latency", 32'(done), 32'd1);
    chk("pulse_count", 32'(pulses), 32'(code));
    chk("per_cycle_led_busy_done", 32'(bad), 32'd0);
  endtask

  initial begin
    rstn = 1'b0; req_valid = '0; req_code = '0;
    repeat (2) @(negedge clk);
    chk("rst_led_off", 32'(led_o), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    rstn = 1'b1;

    // single code 3 from requester 0
    @(negedge clk);
    set_req(0, 3);
    play(0, 3);

    // fresh reset, then 0 and 2 together, then 0 and 1 together
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);
    set_req(0, 2); set_req(2, 1);
    play(0, 2);
    play(2, 1);
    set_req(0, 1); set_req(1, 1);
    play(0, 1);
    play(1, 1);

    // code 0: accepted, done next cycle, nothing shown
    @(negedge clk);
    set_req(1, 0);
    play(1, 0);

    // requester 3 held while requester 2 plays: picked up in the done cycle
    @(negedge clk);
    set_req(2, 1); set_req(3, 2);
    play(2, 1);
    play(3, 2);

    // maximum code
    @(negedge clk);
    set_req(0, 15);
    play(0, 15);

    // reset during the second ON pulse of code 5
    @(negedge clk);
    set_req(0, 5);
    #1;
    chk("abort_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    for (int c = 1; c <= 10; c++) @(negedge clk);
    chk("abort_led_on_before", 32'(led_o), 32'd0);
    rstn = 1'b0;
    #1;
    chk("abort_led_off", 32'(led_o), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("abort_no_done_after", 32'(done), 32'd0);
    set_req(0, 1); set_req(1, 1);
    play(0, 1);
    play(1, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
